cic_comp_fir: RTL and testbench

Decimated-rate compensation FIR placed directly downstream of the 3-stage CIC decimator in the CIC/compensation stage. It consumes the CIC's wide, gain-compensated Q1.15 sample stream and flattens the CIC sinc³ passband droop with an 11-tap symmetric FIR. One time-multiplexed pre-add/MAC unit is used, and the coefficient set is selected by the active decimation code. It emits saturated Q1.15 samples with a single-cycle valid strobe.

---
 rtl/cic_comp_pkg.sv | 38 +++
 rtl/cic_comp_mac.sv | 51 +++++
 rtl/cic_comp_fir.sv | 176 +++++++++++++++++
 tb/tb_cic_comp_fir.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_comp_pkg.sv
// cic_comp_pkg: shared types and constants for the CIC compensation FIR.
//   - state_t     : FSM states (IDLE, MAC, OUT)
//   - *_DEF       : default widths used by cic_comp_fir
//   - COEF        : per-decimation-code coefficient ROM, signed Q1.14,
//                   U unique taps each (index U-1 is the centre tap)
//   - clamp_decim : maps decim_sel codes above 4 onto 4
package cic_comp_pkg;

    localparam int IN_W_DEF      = 32;
    localparam int OUT_W_DEF     = 16;
    localparam int COEF_W_DEF    = 16;
    localparam int COEF_FRAC_DEF = 14;
    localparam int N_TAPS_DEF    = 11;
    localparam int ACC_W_DEF     = 52;
    localparam int U_DEF         = (N_TAPS_DEF + 1) / 2;
    localparam int N_KSETS       = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Row 0 (R=1) is never used for filtering; it is kept as an identity
    // response so the ROM shape stays regular.
    localparam logic signed [COEF_W_DEF-1:0] COEF [N_KSETS][U_DEF] = '{
        '{ 16'sd0,    16'sd0,   16'sd0,    16'sd0,   16'sd0,     16'sd16384 },
        '{ -16'sd20,  16'sd60,  -16'sd150, 16'sd380, -16'sd1000, 16'sd17830 },
        '{ -16'sd32,  16'sd100, -16'sd250, 16'sd600, -16'sd1600, 16'sd18700 },
        '{ -16'sd48,  16'sd140, -16'sd340, 16'sd800, -16'sd2000, 16'sd19300 },
        '{ -16'sd64,  16'sd180, -16'sd420, 16'sd960, -16'sd2400, 16'sd19900 }
    };

    function automatic logic [2:0] clamp_decim(input logic [2:0] sel);
        return (sel > 3'd4) ? 3'd4 : sel;
    endfunction

endpackage

// File: rtl/cic_comp_mac.sv
// cic_comp_mac: symmetric-FIR pre-add / multiply / accumulate datapath.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : clear accumulator (wins over en_i)
//   en_i         : acc += (a_i + b_i) * coef_i
//   a_i, b_i     : signed tap pair (b_i = 0 for the centre tap)
//   coef_i       : signed coefficient
//   acc_o        : signed accumulator
module cic_comp_mac #(
    parameter int IN_W   = 32,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 52
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic signed [IN_W-1:0]   a_i,
    input  logic signed [IN_W-1:0]   b_i,
    input  logic signed [COEF_W-1:0] coef_i,
    output logic signed [ACC_W-1:0]  acc_o
);
    localparam int PW = IN_W + 1;

    logic signed [PW-1:0]        pre_sum;
    logic signed [PW+COEF_W-1:0] product;
    logic signed [ACC_W-1:0]     acc_q, acc_d;

    // One extra bit on the pre-add so the sum of two full-scale taps never wraps.
    assign pre_sum = PW'(a_i) + PW'(b_i);
    assign product = pre_sum * coef_i;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(product);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: 11-tap symmetric compensation FIR behind the CIC decimator.
// One pre-add/MAC unit is time-multiplexed over the U unique coefficients.
//   clk, rst    : clock, asynchronous active-high reset
//   clk_enable  : global qualifier, all state holds when low
//   enable      : low flushes FSM, accumulator, delay line, hold, overrun
//   decim_sel   : decimation code, clamped to 4, selects coefficient set
//   in_valid    : one-cycle sample strobe; in_sample : signed wide sample
//   out_sample  : rounded, saturated Q1.15; out_valid : one-cycle strobe
//   overrun     : sticky dropped-sample flag; busy : FSM not in IDLE
// Handshake: no backpressure. An in_valid seen while busy goes to a one-entry
// hold register; a second one while that is full is dropped and flagged.
module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter int IN_W      = IN_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int COEF_W    = COEF_W_DEF,
    parameter int COEF_FRAC = COEF_FRAC_DEF,
    parameter int N_TAPS    = N_TAPS_DEF,
    parameter int ACC_W     = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_enable,
    input  logic                    enable,
    input  logic [2:0]              decim_sel,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_sample,
    output logic signed [OUT_W-1:0] out_sample,
    output logic                    out_valid,
    output logic                    overrun,
    output logic                    busy
);
    localparam int U  = (N_TAPS + 1) / 2;
    localparam int JW = $clog2(U);
    localparam int XW = $clog2(N_TAPS);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;
    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(2 ** (COEF_FRAC - 1));

    state_t                   state_q, state_d;
    logic [JW-1:0]            j_q;
    logic [2:0]               k_q;
    logic signed [IN_W-1:0]   x_q [N_TAPS];
    logic                     hold_v_q;
    logic signed [IN_W-1:0]   hold_q;
    logic                     overrun_q;
    logic                     out_valid_q;
    logic signed [OUT_W-1:0]  out_q;

    logic                     capture;
    logic signed [IN_W-1:0]   cap_sample;
    logic [2:0]               cap_k;
    logic                     centre;
    logic [XW-1:0]            tap_j, tap_m;
    logic signed [IN_W-1:0]   mac_a, mac_b;
    logic signed [COEF_W-1:0] mac_coef;
    logic                     mac_clr, mac_en;
    logic signed [ACC_W-1:0]  acc, acc_shr;

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[OUT_W-1:0];
        else if (v < SAT_MIN) return SAT_MIN[OUT_W-1:0];
        else return v[OUT_W-1:0];
    endfunction

    // The held sample is older than any new strobe, so it is taken first.
    assign capture    = enable && (state_q == ST_IDLE) && (in_valid || hold_v_q);
    assign cap_sample = hold_v_q ? hold_q : in_sample;
    assign cap_k      = clamp_decim(decim_sel);

    // Tap pair for MAC step j: x[j] + x[N_TAPS-1-j]; the centre tap has no partner.
    assign centre   = (j_q == JW'(U - 1));
    assign tap_j    = XW'(j_q);
    assign tap_m    = XW'(N_TAPS - 1) - tap_j;
    assign mac_a    = x_q[tap_j];
    assign mac_b    = centre ? '0 : x_q[tap_m];
    assign mac_coef = COEF[k_q][j_q];
    assign mac_clr  = clk_enable && (!enable || capture);
    assign mac_en   = clk_enable && enable && (state_q == ST_MAC);
    assign acc_shr  = (acc + RND) >>> COEF_FRAC;

    cic_comp_mac #(
        .IN_W   (IN_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (mac_clr),
        .en_i   (mac_en),
        .a_i    (mac_a),
        .b_i    (mac_b),
        .coef_i (mac_coef),
        .acc_o  (acc)
    );

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (capture) state_d = (cap_k == 3'd0) ? ST_OUT : ST_MAC;
                ST_MAC:  if (centre) state_d = ST_OUT;
                ST_OUT:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (clk_enable) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j_q         <= '0;
            k_q         <= '0;
            hold_v_q    <= 1'b0;
            hold_q      <= '0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            for (int i = 0; i < N_TAPS; i++) x_q[i] <= '0;
        end else if (clk_enable) begin
            out_valid_q <= 1'b0;
            if (!enable) begin
                // out_q deliberately keeps the last emitted sample.
                j_q       <= '0;
                hold_v_q  <= 1'b0;
                hold_q    <= '0;
                overrun_q <= 1'b0;
                for (int i = 0; i < N_TAPS; i++) x_q[i] <= '0;
            end else begin
                if (capture) begin
                    x_q[0] <= cap_sample;
                    for (int i = 1; i < N_TAPS; i++) x_q[i] <= x_q[i-1];
                    k_q <= cap_k;
                    j_q <= '0;
                end
                if (state_q == ST_MAC) begin
                    j_q <= j_q + JW'(1);
                end
                if (state_q == ST_IDLE) begin
                    // Held sample is consumed now; a simultaneous strobe refills it.
                    if (hold_v_q) begin
                        hold_v_q <= in_valid;
                        if (in_valid) hold_q <= in_sample;
                    end
                end else if (in_valid) begin
                    if (!hold_v_q) begin
                        hold_v_q <= 1'b1;
                        hold_q   <= in_sample;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                end
                if (state_q == ST_OUT) begin
                    out_valid_q <= 1'b1;
                    out_q <= (k_q == 3'd0) ? sat_out(ACC_W'(x_q[0])) : sat_out(acc_shr);
                end
            end
        end
    end

    assign out_sample = out_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cic_comp_fir.sv
module tb_cic_comp_fir;

  logic               clk = 1'b0;
  logic               rst;
  logic               clk_enable;
  logic               enable;
  logic [2:0]         decim_sel;
  logic               in_valid;
  logic signed [31:0] in_sample;
  logic signed [15:0] out_sample;
  logic               out_valid;
  logic               overrun;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  // Reference: full 11-tap convolution over the captured-sample history.
  longint hist[11];
  int coef_tab[5][6] = '{
    '{   0,   0,    0,   0,     0, 16384 },
    '{ -20,  60, -150, 380, -1000, 17830 },
    '{ -32, 100, -250, 600, -1600, 18700 },
    '{ -48, 140, -340, 800, -2000, 19300 },
    '{ -64, 180, -420, 960, -2400, 19900 }
  };
  logic [15:0] exp_q[$];

  cic_comp_fir dut (
    .clk        (clk),
    .rst        (rst),
    .clk_enable (clk_enable),
    .enable     (enable),
    .decim_sel  (decim_sel),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int i = 0; i < 11; i++) hist[i] = 0;
  endtask

  task automatic model_capture(input logic signed [31:0] s, input logic [2:0] dsel,
                               output logic signed [15:0] y);
    int k;
    longint acc;
    longint r;
    k = (dsel > 3'd4) ? 4 : int'(dsel);
    for (int i = 10; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    if (k == 0) begin
      r = hist[0];
    end else begin
      acc = 0;
      for (int i = 0; i < 11; i++) acc += hist[i] * coef_tab[k][(i <= 5) ? i : 10 - i];
      r = (acc + 8192) >>> 14;
    end
    if (r > 32767) y = 16'sh7fff;
    else if (r < -32768) y = 16'sh8000;
    else y = r[15:0];
  endtask

  // Driver: one strobe, then wait (bounded) for out_valid. lat = edges after capture, -1 on timeout.
  task automatic send(input logic signed [31:0] s, output logic signed [15:0] y, output int lat,
                      output logic busy_cap, output logic busy_end);
    in_sample = s;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    busy_cap = busy;
    lat = -1;
    y = 'x;
    busy_end = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        y = out_sample;
        busy_end = busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (out_sample !== 16'sd0) begin failures++; $display("FAIL reset_out_sample got=%0d exp=0", out_sample); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_impulse();
    logic signed [15:0] y, m, e;
    int lat;
    logic bc, be;
    decim_sel = 3'd2;
    for (int i = 0; i < 11; i++) begin
      send((i == 0) ? 32'sd16384 : 32'sd0, y, lat, bc, be);
      model_capture((i == 0) ? 32'sd16384 : 32'sd0, decim_sel, m);
      e = 16'(coef_tab[2][(i <= 5) ? i : 10 - i]);
      checks++; if (y !== e) begin failures++; $display("FAIL impulse_tap%0d got=%0d exp=%0d", i, y, e); end
      checks++; if (lat != 7) begin failures++; $display("FAIL impulse_latency%0d got=%0d exp=7", i, lat); end
      if (i == 0) begin
        checks++; if (bc !== 1'b1) begin failures++; $display("FAIL impulse_busy_at_capture got=%b exp=1", bc); end
        checks++; if (be !== 1'b0) begin failures++; $display("FAIL impulse_busy_at_out got=%b exp=0", be); end
      end
    end
  endtask

  task automatic test_dc();
    logic signed [15:0] y, m;
    int lat;
    logic bc, be;
    decim_sel = 3'd4;
    for (int i = 0; i < 40; i++) begin
      send(32'sd8192, y, lat, bc, be);
      model_capture(32'sd8192, decim_sel, m);
      checks++; if (y !== m || lat != 7) begin failures++; $display("FAIL dc_sample%0d got=%0d exp=%0d lat=%0d", i, y, m, lat); end
      if (i >= 10) begin
        checks++; if (y !== 16'sd8206) begin failures++; $display("FAIL dc_settled%0d got=%0d exp=8206", i, y); end
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] y, m;
    int lat;
    logic bc, be;
    logic signed [31:0] s;
    decim_sel = 3'd1;
    for (int i = 0; i < 22; i++) begin
      s = (i < 11) ? 32'sh7fff_ffff : 32'sh8000_0000;
      send(s, y, lat, bc, be);
      model_capture(s, decim_sel, m);
      checks++; if (y !== m) begin failures++; $display("FAIL sat_sample%0d got=%0d exp=%0d", i, y, m); end
    end
    checks++; if (y !== 16'sh8000) begin failures++; $display("FAIL sat_negative got=%0h exp=8000", y); end
    s = 32'sh7fff_ffff;
    for (int i = 0; i < 11; i++) begin
      send(s, y, lat, bc, be);
      model_capture(s, decim_sel, m);
    end
    checks++; if (y !== 16'sh7fff) begin failures++; $display("FAIL sat_positive got=%0h exp=7fff", y); end
  endtask

  task automatic test_overrun();
    logic signed [31:0] s1, s2, s3;
    logic signed [15:0] m1, m2;
    logic signed [15:0] got[2];
    int at[2];
    int seen;
    enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    model_clear();
    decim_sel = 3'd2;
    s1 = 32'($urandom_range(0, 40000)) - 32'sd20000;
    s2 = 32'($urandom_range(0, 40000)) - 32'sd20000;
    s3 = 32'($urandom_range(0, 40000)) - 32'sd20000;
    model_capture(s1, decim_sel, m1);
    model_capture(s2, decim_sel, m2);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear_before got=%b exp=0", overrun); end
    in_valid = 1'b1; in_sample = s1;
    @(posedge clk); #1;
    in_sample = s2;
    @(posedge clk); #1;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_held_not_dropped got=%b exp=0", overrun); end
    in_sample = s3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    seen = 0;
    for (int n = 3; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (seen < 2) begin got[seen] = out_sample; at[seen] = n; end
        seen++;
      end
    end
    checks++; if (seen != 2) begin failures++; $display("FAIL overrun_output_count got=%0d exp=2", seen); end
    if (seen >= 2) begin
      checks++; if (got[0] !== m1 || at[0] != 7) begin failures++; $display("FAIL overrun_first got=%0d@%0d exp=%0d@7", got[0], at[0], m1); end
      checks++; if (got[1] !== m2 || at[1] != 15) begin failures++; $display("FAIL overrun_held got=%0d@%0d exp=%0d@15", got[1], at[1], m2); end
    end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
    enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    model_clear();
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_cleared got=%b exp=0", overrun); end
  endtask

  task automatic test_bypass();
    logic signed [15:0] y, m;
    int lat;
    logic bc, be;
    decim_sel = 3'd0;
    send(32'sd40000, y, lat, bc, be);
    model_capture(32'sd40000, decim_sel, m);
    checks++; if (y !== 16'sd32767) begin failures++; $display("FAIL bypass_sat got=%0d exp=32767", y); end
    checks++; if (lat != 1) begin failures++; $display("FAIL bypass_latency got=%0d exp=1", lat); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bypass_strobe_width got=%b exp=0", out_valid); end
    send(-32'sd5, y, lat, bc, be);
    model_capture(-32'sd5, decim_sel, m);
    checks++; if (y !== -16'sd5) begin failures++; $display("FAIL bypass_neg got=%0d exp=-5", y); end
    decim_sel = 3'd7;
    send(32'sd12345, y, lat, bc, be);
    model_capture(32'sd12345, decim_sel, m);
    checks++; if (y !== m || lat != 7) begin failures++; $display("FAIL clamp_sel7 got=%0d lat=%0d exp=%0d", y, lat, m); end
  endtask

  task automatic test_flush();
    logic signed [15:0] y, m, e, last_y;
    int lat, seen;
    logic bc, be;
    logic signed [31:0] s;
    for (int v = 0; v < 2; v++) begin
      decim_sel = 3'd2;
      for (int i = 0; i < 3; i++) begin
        s = 32'($urandom_range(0, 60000)) - 32'sd30000;
        send(s, y, lat, bc, be);
        model_capture(s, decim_sel, m);
      end
      last_y = y;
      in_sample = 32'sd22222; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (v == 0) enable = 1'b0; else rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush%0d_busy got=%b exp=0", v, busy); end
      checks++; if (out_sample !== ((v == 0) ? last_y : 16'sd0)) begin failures++; $display("FAIL flush%0d_out_sample got=%0d", v, out_sample); end
      enable = 1'b1; rst = 1'b0;
      model_clear();
      seen = 0;
      for (int n = 0; n < 12; n++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL flush%0d_no_output got=%0d exp=0", v, seen); end
      for (int i = 0; i < 11; i++) begin
        send((i == 0) ? 32'sd16384 : 32'sd0, y, lat, bc, be);
        model_capture((i == 0) ? 32'sd16384 : 32'sd0, decim_sel, m);
        e = 16'(coef_tab[2][(i <= 5) ? i : 10 - i]);
        checks++; if (y !== e || lat != 7) begin failures++; $display("FAIL flush%0d_impulse%0d got=%0d exp=%0d", v, i, y, e); end
      end
    end
  endtask

  task automatic test_clk_enable();
    logic signed [15:0] y, m;
    int lat;
    logic signed [31:0] s;
    decim_sel = 3'd3;
    s = 32'($urandom_range(0, 200000)) - 32'sd100000;
    model_capture(s, decim_sel, m);
    in_sample = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1; y = 'x;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (n == 3) clk_enable = 1'b0;
      if (n == 8) clk_enable = 1'b1;
      if (out_valid) begin lat = n; y = out_sample; break; end
    end
    checks++; if (y !== m) begin failures++; $display("FAIL freeze_value got=%0d exp=%0d", y, m); end
    checks++; if (lat != 12) begin failures++; $display("FAIL freeze_latency got=%0d exp=12", lat); end
  endtask

  task automatic test_random();
    logic signed [15:0] y, m;
    logic [15:0] e;
    int lat;
    logic bc, be;
    logic signed [31:0] s;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      decim_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) s = $urandom();
      else s = 32'($urandom_range(0, 2097152)) - 32'sd1048576;
      model_capture(s, decim_sel, m);
      exp_q.push_back(m);
      send(s, y, lat, bc, be);
      e = exp_q.pop_front();
      checks++; if (y !== e || lat != ((decim_sel == 3'd0) ? 1 : 7)) begin
        failures++; $display("FAIL random%0d k=%0d got=%0d lat=%0d exp=%0d", i, decim_sel, y, lat, $signed(e));
      end
    end
  endtask

  initial begin
    rst = 1'b1; clk_enable = 1'b1; enable = 1'b1; decim_sel = 3'd0;
    in_valid = 1'b0; in_sample = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_impulse();
    test_dc();
    test_saturation();
    test_overrun();
    test_bypass();
    test_flush();
    test_clk_enable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
